// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter.
// Each accepted load sends a sync preamble, then the payload MSB first, then an idle gap.
module seq_frame_tx #(
  parameter int unsigned W        = 8,
  parameter int unsigned GAP      = 2,
  parameter logic [4:0]  PREAMBLE = 5'b10110
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] data_in,
  input  logic         load,
  input  logic         abort,
  output logic         ready,
  output logic         xout,
  output logic         frame_done
);

  localparam int unsigned CW = $clog2(W) + 1;
  localparam int unsigned PW = 3;
  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

  state_t          state, state_n;
  logic [W-1:0]    shreg, shreg_n;
  logic [PW-1:0]   pre_cnt, pre_cnt_n;
  logic [CW-1:0]   bit_cnt, bit_cnt_n;
  logic [GW-1:0]   gap_cnt, gap_cnt_n;
  logic            xout_n, frame_done_n, ready_n;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      pre_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      xout       <= 1'b0;
      frame_done <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      pre_cnt    <= pre_cnt_n;
      bit_cnt    <= bit_cnt_n;
      gap_cnt    <= gap_cnt_n;
      xout       <= xout_n;
      frame_done <= frame_done_n;
      ready      <= ready_n;
    end
  end

  // Next state and next output values; xout_n is the bit shown in the coming cycle.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    pre_cnt_n    = pre_cnt;
    bit_cnt_n    = bit_cnt;
    gap_cnt_n    = gap_cnt;
    xout_n       = 1'b0;
    frame_done_n = 1'b0;

    case (state)
      S_IDLE: begin
        if (load && !abort) begin
          shreg_n   = data_in;
          pre_cnt_n = PW'(4);
          xout_n    = PREAMBLE[4];
          state_n   = S_PRE;
        end
      end
      S_PRE: begin
        if (pre_cnt == '0) begin
          xout_n       = shreg[W-1];
          shreg_n      = shreg << 1;
          bit_cnt_n    = CW'(W - 1);
          frame_done_n = (W == 1);
          state_n      = S_DATA;
        end else begin
          pre_cnt_n = pre_cnt - PW'(1);
          xout_n    = PREAMBLE[pre_cnt_n];
        end
      end
      S_DATA: begin
        if (bit_cnt == '0) begin
          shreg_n   = '0;
          gap_cnt_n = GW'(GAP - 1);
          state_n   = S_GAP;
        end else begin
          xout_n       = shreg[W-1];
          shreg_n      = shreg << 1;
          bit_cnt_n    = bit_cnt - CW'(1);
          frame_done_n = (bit_cnt == CW'(1));
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Abort drops any frame in flight and clears the datapath.
    if (abort && (state != S_IDLE)) begin
      state_n      = S_IDLE;
      shreg_n      = '0;
      pre_cnt_n    = '0;
      bit_cnt_n    = '0;
      gap_cnt_n    = '0;
      xout_n       = 1'b0;
      frame_done_n = 1'b0;
    end

    ready_n = (state_n == S_IDLE);
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: per-cycle expectations queued at load time, popped each cycle.
module tb_seq_frame_tx;

  typedef struct packed {
    logic x;
    logic fd;
    logic rdy;
    logic det;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data8;
  logic       load8, abort8, rdy8, xout8, fd8;
  logic [0:0] data1;
  logic       load1, abort1, rdy1, xout1, fd1;

  int   errors = 0;
  int   checks = 0;
  logic [4:0] hist = '0;
  exp_t q8[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  seq_frame_tx #(.W(8), .GAP(2)) dut8 (
    .clk(clk), .reset_n(reset_n), .data_in(data8), .load(load8), .abort(abort8),
    .ready(rdy8), .xout(xout8), .frame_done(fd8)
  );

  seq_frame_tx #(.W(1), .GAP(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .data_in(data1), .load(load1), .abort(abort1),
    .ready(rdy1), .xout(xout1), .frame_done(fd1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t e;
    e.x = 1'b0; e.fd = 1'b0; e.rdy = 1'b1; e.det = 1'b0;
    return e;
  endfunction

  task automatic push_e(input int which, input exp_t e);
    if (which == 8) q8.push_back(e);
    else            q1.push_back(e);
  endtask

  // Expected line activity for cycles 1..5+w+gap after the accepting edge.
  task automatic push_frame(input int which, input logic [31:0] d, input int w, input int gap);
    logic [4:0] pre;
    exp_t e;
    pre = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      e.x = pre[4-i]; e.fd = 1'b0; e.rdy = 1'b0; e.det = (i == 4);
      push_e(which, e);
    end
    for (int i = 0; i < w; i++) begin
      e.x = d[w-1-i]; e.fd = (i == w - 1); e.rdy = 1'b0; e.det = 1'b0;
      push_e(which, e);
    end
    for (int i = 0; i < gap; i++) begin
      e.x = 1'b0; e.fd = 1'b0; e.rdy = 1'b0; e.det = 1'b0;
      push_e(which, e);
    end
  endtask

  // One clock: inputs already set, compare the cycle following the edge.
  task automatic tick();
    exp_t e8, e1;
    @(posedge clk);
    @(negedge clk);
    hist = {hist[3:0], xout8};
    e8 = (q8.size() > 0) ? q8.pop_front() : idle_e();
    e1 = (q1.size() > 0) ? q1.pop_front() : idle_e();
    check("xout_w8",  32'(xout8), 32'(e8.x));
    check("done_w8",  32'(fd8),   32'(e8.fd));
    check("ready_w8", 32'(rdy8),  32'(e8.rdy));
    check("det_w8",   32'(hist == 5'b10110), 32'(e8.det));
    check("xout_w1",  32'(xout1), 32'(e1.x));
    check("done_w1",  32'(fd1),   32'(e1.fd));
    check("ready_w1", 32'(rdy1),  32'(e1.rdy));
  endtask

  initial begin
    reset_n = 1'b0;
    data8 = '0; load8 = 1'b0; abort8 = 1'b0;
    data1 = '0; load1 = 1'b0; abort1 = 1'b0;
    #12;
    check("rst_xout",  32'(xout8), 32'(0));
    check("rst_ready", 32'(rdy8),  32'(1));
    check("rst_done",  32'(fd8),   32'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // A5 frame on W=8, single-bit frame on W=1; data changes after acceptance are ignored.
    load8 = 1'b1; data8 = 8'hA5; load1 = 1'b1; data1 = 1'b1;
    push_frame(8, 32'hA5, 8, 2);
    push_frame(1, 32'h1, 1, 1);
    tick();
    load8 = 1'b0; load1 = 1'b0; data8 = 8'h5A; data1 = 1'b0;
    repeat (16) tick();

    // Abort and load together in idle: nothing starts.
    load8 = 1'b1; abort8 = 1'b1;
    tick();
    load8 = 1'b0; abort8 = 1'b0;
    tick();

    // load held high: second frame accepted at E16, mid-frame data change ignored.
    load8 = 1'b1; data8 = 8'h00;
    push_frame(8, 32'h00, 8, 2);
    q8.push_back(idle_e());
    push_frame(8, 32'hFF, 8, 2);
    tick();
    data8 = 8'hFF;
    repeat (16) tick();
    load8 = 1'b0;
    repeat (16) tick();

    // Abort during payload bit 6, then a fresh frame at E8.
    load8 = 1'b1; data8 = 8'h3C;
    push_frame(8, 32'h3C, 8, 2);
    tick();
    load8 = 1'b0;
    repeat (6) tick();
    abort8 = 1'b1;
    q8.delete();
    q8.push_back(idle_e());
    tick();
    abort8 = 1'b0; load8 = 1'b1; data8 = 8'hA5;
    push_frame(8, 32'hA5, 8, 2);
    tick();
    load8 = 1'b0;
    repeat (16) tick();

    // Asynchronous reset mid-preamble while xout is high.
    load8 = 1'b1; data8 = 8'h3C;
    push_frame(8, 32'h3C, 8, 2);
    tick();
    load8 = 1'b0;
    tick();
    tick();
    check("pre_rst_xout", 32'(xout8), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_xout",  32'(xout8), 32'(0));
    check("arst_ready", 32'(rdy8),  32'(1));
    check("arst_done",  32'(fd8),   32'(0));
    q8.delete();
    q1.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) tick();

    // Normal operation after reset.
    load8 = 1'b1; data8 = 8'h81;
    push_frame(8, 32'h81, 8, 2);
    tick();
    load8 = 1'b0;
    repeat (17) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
